// File: rtl/product_accumulator.sv
// Accumulates a run of 2x2 multiplier products into a wrapping sum with a sticky overflow flag.
// A run is started with a product count, can be aborted, and its result is held until acknowledged.
module product_accumulator #(
    parameter int unsigned ACC_W = 6,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             p_valid,
    input  logic [3:0]       p_data,
    output logic             p_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             done,
    input  logic             ack,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;

    // One extra bit captures the carry out of the accumulator MSB.
    logic [ACC_W:0]   sum_ext;
    logic             last_xfer;

    assign sum_ext   = {1'b0, sum_q} + (ACC_W + 1)'(p_data);
    assign last_xfer = (cnt_q == len_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (len == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                // Abort wins over a coincident product; p_ready is already low.
                if (abort) begin
                    state_d = StIdle;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end else if (p_valid) begin
                    sum_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_xfer) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign p_ready = (state_q == StAcc) & ~abort;
    assign sum     = sum_q;
    assign ovf     = ovf_q;
    assign done    = (state_q == StDone);
    assign busy    = (state_q != StIdle);

endmodule
